// File: rtl/move_key_cond_if.sv
// Signal bundle between the move-key conditioner and its environment:
// game state and raw buttons in, one-hot direction levels and busy out.
interface move_key_cond_if;
    logic [1:0] state;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       busy;

    modport master (
        output state, btn_up, btn_down, btn_left, btn_right,
        input  up, down, left, right, busy
    );

    modport slave (
        input  state, btn_up, btn_down, btn_left, btn_right,
        output up, down, left, right, busy
    );
endinterface

// File: rtl/move_key_cond.sv
// Button conditioner for the maze move stage: sync, debounce, one timed pulse per press.
// Define MOVE_KEY_AUTOREPEAT_EN to add auto-repeat pulses while a button stays held.
//
// state | meaning
// IDLE  | outputs 0, waiting for a press event while playing
// EMIT  | latched direction driven high for HOLD_CYCLES cycles
// WAIT  | outputs 0, waiting for full release (or repeat timer expiry)
module move_key_cond #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 2500000,
    parameter int REPEAT_DELAY    = 5000000
) (
    input  logic           clk,
    input  logic           rst_n,
    move_key_cond_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX  = (HOLD_CYCLES > REPEAT_DELAY) ? HOLD_CYCLES : REPEAT_DELAY;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [1:0] PLAYING = 2'b10;

    typedef enum logic [1:0] {IDLE, EMIT, WAIT} fsm_t;

    // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       rise;

    fsm_t             fsm;
    logic [3:0]       dir;
    logic [TMR_W-1:0] timer;
    logic             busy_q;

    function automatic logic [3:0] pick(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else if (v[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    assign raw  = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
    assign rise = stable & ~stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                        stable[i] <= ~stable[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm    <= IDLE;
            dir    <= '0;
            timer  <= '0;
            busy_q <= 1'b0;
        end else if (bus.state != PLAYING) begin
            fsm    <= IDLE;
            dir    <= '0;
            timer  <= '0;
            busy_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (|rise) begin
                        dir    <= pick(rise);
                        timer  <= TMR_W'(HOLD_CYCLES - 1);
                        fsm    <= EMIT;
                        busy_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (timer == '0) begin
                        dir <= '0;
                        fsm <= WAIT;
`ifdef MOVE_KEY_AUTOREPEAT_EN
                        timer <= TMR_W'(REPEAT_DELAY - 1);
`endif
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT: begin
                    if (stable == '0) begin
                        fsm    <= IDLE;
                        busy_q <= 1'b0;
                    end
`ifdef MOVE_KEY_AUTOREPEAT_EN
                    else if (timer == '0) begin
                        dir   <= pick(stable);
                        timer <= TMR_W'(HOLD_CYCLES - 1);
                        fsm   <= EMIT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
`endif
                end
                default: begin
                    fsm    <= IDLE;
                    dir    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.up    = dir[3];
    assign bus.down  = dir[2];
    assign bus.left  = dir[1];
    assign bus.right = dir[0];
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_move_key_cond.sv
// Bench for move_key_cond: directed scenarios plus random buttons/state,
// compared every cycle against a behavioural press/pulse model.
module tb_move_key_cond;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 20;
`ifdef MOVE_KEY_AUTOREPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    move_key_cond_if bus();

    move_key_cond #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD),
        .REPEAT_DELAY(REP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model; bit order [3]=up [2]=down [1]=left [0]=right
    logic [3:0] m_q1 = '0, m_q2 = '0, m_stable = '0, m_prev = '0, m_dir = '0;
    logic [3:0] m_raw, m_rose;
    int  m_run [4] = '{0, 0, 0, 0};
    int  m_left = 0;
    int  m_rep = 0;
    bit  m_wait = 1'b0;

    function automatic logic [3:0] top_of(input logic [3:0] v);
        for (int i = 3; i >= 0; i--)
            if (v[i]) return 4'b0001 << i;
        return 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q1 = '0; m_q2 = '0; m_stable = '0; m_prev = '0; m_dir = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_left = 0; m_rep = 0; m_wait = 1'b0;
        end else begin
            m_raw  = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
            m_rose = m_stable & ~m_prev;
            if (bus.state != 2'b10) begin
                m_left = 0; m_wait = 1'b0; m_dir = '0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_wait = 1'b1; m_rep = REP; end
            end else if (m_wait) begin
                if (m_stable == 4'b0000) m_wait = 1'b0;
                else if (REPEAT_ON) begin
                    if (m_rep == 1) begin
                        m_dir = top_of(m_stable); m_left = HOLD; m_wait = 1'b0;
                    end else m_rep--;
                end
            end else if (m_rose != 4'b0000) begin
                m_dir = top_of(m_rose); m_left = HOLD;
            end
            // Debounced level flips after DEB+1 consecutive disagreeing samples
            m_prev = m_stable;
            for (int i = 0; i < 4; i++) begin
                if (m_q2[i] != m_stable[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DEB + 1) begin m_stable[i] = ~m_stable[i]; m_run[i] = 0; end
            end
            m_q2 = m_q1;
            m_q1 = m_raw;
        end
    end

    wire [3:0] dut_dirs = {bus.up, bus.down, bus.left, bus.right};
    wire [3:0] m_out    = (m_left > 0) ? m_dir : 4'b0000;
    wire       m_busy   = (m_left > 0) || m_wait;

    always @(negedge clk) begin
        checks += 2;
        if (dut_dirs !== m_out) begin
            failures++;
            $display("FAIL cycle_dirs cyc=%0d got=%b want=%b", cyc, dut_dirs, m_out);
        end
        if (bus.busy !== m_busy) begin
            failures++;
            $display("FAIL cycle_busy cyc=%0d got=%b want=%b", cyc, bus.busy, m_busy);
        end
    end

    // Edge trackers, relative to scenario start edge
    int rise_cnt [4];
    int rise_at [4][4];
    int first_fall [4];
    int busy_fall;
    logic [3:0] prev_d = '0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dut_dirs[i] && !prev_d[i]) begin
                if (rise_cnt[i] < 4) rise_at[i][rise_cnt[i]] = cyc - base;
                rise_cnt[i]++;
            end
            if (!dut_dirs[i] && prev_d[i] && first_fall[i] < 0) first_fall[i] = cyc - base;
        end
        if (!bus.busy && prev_busy && busy_fall < 0) busy_fall = cyc - base;
        prev_d = dut_dirs;
        prev_busy = bus.busy;
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic start_scn();
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] = 0;
            first_fall[i] = -1;
            for (int k = 0; k < 4; k++) rise_at[i][k] = -1;
        end
        busy_fall = -1;
        base = cyc + 1;
    endtask

    task automatic set_btns(input logic [3:0] b);
        bus.btn_up = b[3]; bus.btn_down = b[2]; bus.btn_left = b[1]; bus.btn_right = b[0];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int waited;
        bus.state = 2'b10;
        set_btns(4'b1111);
        start_scn();
        idle(5);
        check_val("reset_outputs", int'({dut_dirs, bus.busy}), 0);

        // Held through reset and through enable: no pulse
        bus.state = 2'b01;
        rst_n = 1'b1;
        start_scn();
        idle(20);
        bus.state = 2'b10;
        idle(30);
        check_val("held_no_pulse", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 0);
        set_btns(4'b0000);
        idle(20);

        // Clean press held 40 cycles
        start_scn();
        set_btns(4'b1000);
        idle(40);
        set_btns(4'b0000);
        idle(30);
        check_val("clean_rise", rise_at[3][0], 7);
        check_val("clean_fall", first_fall[3], 17);
        check_val("clean_count", rise_cnt[3], REPEAT_ON ? 2 : 1);
        check_val("clean_busy_fall", busy_fall, REPEAT_ON ? 48 : 47);

        // Bounce on left, then steady high from edge 20
        start_scn();
        for (int k = 0; k < 10; k++) begin
            set_btns((k % 2 == 0) ? 4'b0010 : 4'b0000);
            idle(2);
        end
        set_btns(4'b0010);
        idle(30);
        set_btns(4'b0000);
        idle(30);
        check_val("bounce_count", rise_cnt[1], 1);
        check_val("bounce_rise", rise_at[1][0], 27);

        // Simultaneous down + right
        start_scn();
        set_btns(4'b0101);
        idle(25);
        set_btns(4'b0000);
        idle(30);
        check_val("simul_down_rise", rise_at[2][0], 7);
        check_val("simul_down_count", rise_cnt[2], 1);
        check_val("simul_right_count", rise_cnt[0], 0);

        // State gate mid-pulse
        start_scn();
        set_btns(4'b1000);
        idle(11);
        bus.state = 2'b01;
        idle(10);
        bus.state = 2'b10;
        idle(30);
        set_btns(4'b0000);
        idle(30);
        check_val("gate_fall", first_fall[3], 11);
        check_val("gate_busy_fall", busy_fall, 11);
        check_val("gate_count", rise_cnt[3], 1);

        // Auto-repeat train on right
        start_scn();
        set_btns(4'b0001);
        idle(90);
        set_btns(4'b0000);
        idle(40);
        check_val("rep_first", rise_at[0][0], 7);
        check_val("rep_second", rise_at[0][1], REPEAT_ON ? 37 : -1);
        check_val("rep_third", rise_at[0][2], REPEAT_ON ? 67 : -1);
        check_val("rep_count", rise_cnt[0], REPEAT_ON ? 3 : 1);

        // Asynchronous reset during a pulse
        set_btns(4'b1000);
        waited = 0;
        while (!bus.up && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check_val("midpulse_up_seen", int'(bus.up), 1);
        #1 rst_n = 1'b0;
        #1 check_val("async_reset_drop", int'({dut_dirs, bus.busy}), 0);
        @(negedge clk);
        set_btns(4'b0000);
        rst_n = 1'b1;
        idle(20);

        // Random buttons and occasional state changes
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) bus.btn_up    = ~bus.btn_up;
            if ($urandom_range(0, 11) == 0) bus.btn_down  = ~bus.btn_down;
            if ($urandom_range(0, 11) == 0) bus.btn_left  = ~bus.btn_left;
            if ($urandom_range(0, 11) == 0) bus.btn_right = ~bus.btn_right;
            if (bus.state == 2'b10) begin
                if ($urandom_range(0, 299) == 0) bus.state = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 19) == 0) begin
                bus.state = 2'b10;
            end
        end
        set_btns(4'b0000);
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
